en_gen_blk: RTL and testbench

//  Programmable sample-enable generator for the Goertzel datapath. Divides clk by a

---
 rtl/en_gen_blk_if.sv | 28 ++
 rtl/en_gen_blk.sv | 118 +++++++++++
 tb/tb_en_gen_blk.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/en_gen_blk_if.sv
// Control/strobe bundle for en_gen_blk. sync_in only exists when EN_GEN_SYNC_EN is defined.
interface en_gen_blk_if #(
  parameter int CNT_W = 10,
  parameter int BLK_W = 8
);
  logic             run;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
`ifdef EN_GEN_SYNC_EN
  logic             sync_in;
`endif
  logic             en_out;
  logic             blk_end;
  logic [BLK_W-1:0] sample_idx;
  logic             busy;

`ifdef EN_GEN_SYNC_EN
  modport master (output run, div_load, div_value, sync_in,
                  input  en_out, blk_end, sample_idx, busy);
  modport slave  (input  run, div_load, div_value, sync_in,
                  output en_out, blk_end, sample_idx, busy);
`else
  modport master (output run, div_load, div_value,
                  input  en_out, blk_end, sample_idx, busy);
  modport slave  (input  run, div_load, div_value,
                  output en_out, blk_end, sample_idx, busy);
`endif
endinterface

// File: rtl/en_gen_blk.sv
// Programmable sample-enable divider with block-of-BLK_LEN sample indexing.
// Optional EN_GEN_SYNC_EN adds sync_in realignment of the divider and block index.
module en_gen_blk #(
  parameter int CNT_W       = 10,
  parameter int DIV_DEFAULT = 999,
  parameter int BLK_W       = 8,
  parameter int BLK_LEN     = 205
) (
  input  logic         clk,
  input  logic         rst,
  en_gen_blk_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [BLK_W-1:0] LAST = BLK_W'(BLK_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic [BLK_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             en_q, en_d;
  logic             blk_q, blk_d;
  logic [CNT_W-1:0] div_nxt;
  logic [BLK_W-1:0] idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DIV_DEFAULT);
      pval_q  <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      first_q <= 1'b0;
      en_q    <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      en_q    <= en_d;
      blk_q   <= blk_d;
    end
  end

  // A load arriving on the same edge as the apply point beats an older pending one.
  assign div_nxt = bus.div_load ? bus.div_value : (pend_q ? pval_q : div_q);
  assign idx_nxt = (first_q || idx_q == LAST) ? '0 : idx_q + BLK_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    first_d = first_q;
    en_d    = 1'b0;
    blk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        pend_d = 1'b0;
        if (bus.div_load) div_d = bus.div_value;
        if (bus.run) begin
          state_d = RUN;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (!bus.run) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          div_d   = div_nxt;
          pend_d  = 1'b0;
        end
`ifdef EN_GEN_SYNC_EN
        else if (bus.sync_in) begin
          cnt_d   = '0;
          first_d = 1'b1;
          div_d   = div_nxt;
          pend_d  = 1'b0;
        end
`endif
        else if (cnt_q == div_q) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          div_d   = div_nxt;
          pend_d  = 1'b0;
          idx_d   = idx_nxt;
          blk_d   = (idx_nxt == LAST);
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.div_load) begin
            pend_d = 1'b1;
            pval_d = bus.div_value;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.en_out     = en_q;
  assign bus.blk_end    = blk_q;
  assign bus.sample_idx = idx_q;
  assign bus.busy       = (state_q == RUN);
endmodule

// File: tb/tb_en_gen_blk.sv
// Scoreboard bench for en_gen_blk: three instances (BLK_LEN 205, 4, 1) share one stimulus.
module tb_en_gen_blk;
  localparam int LA = 205;
  localparam int LB = 4;
  localparam int LC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  en_gen_blk_if #(.CNT_W(10), .BLK_W(8)) if_a ();
  en_gen_blk_if #(.CNT_W(10), .BLK_W(8)) if_b ();
  en_gen_blk_if #(.CNT_W(10), .BLK_W(8)) if_c ();

  assign if_b.run       = if_a.run;
  assign if_b.div_load  = if_a.div_load;
  assign if_b.div_value = if_a.div_value;
  assign if_c.run       = if_a.run;
  assign if_c.div_load  = if_a.div_load;
  assign if_c.div_value = if_a.div_value;
`ifdef EN_GEN_SYNC_EN
  assign if_b.sync_in   = if_a.sync_in;
  assign if_c.sync_in   = if_a.sync_in;
`endif

  en_gen_blk #(.BLK_LEN(LA)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  en_gen_blk #(.BLK_LEN(LB)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  en_gen_blk #(.BLK_LEN(LC)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct {
    int cyc;
    int ia, ib, ic;
    int ba, bb, bc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k = strobe ordinal since entering RUN (or since a sync realignment)
  task automatic push(input int c, input int k);
    exp_t x;
    x.cyc = c;
    x.ia = k % LA; x.ba = (x.ia == LA - 1) ? 1 : 0;
    x.ib = k % LB; x.bb = (x.ib == LB - 1) ? 1 : 0;
    x.ic = k % LC; x.bc = (x.ic == LC - 1) ? 1 : 0;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load(input int v);
    if_a.div_load  = 1'b1;
    if_a.div_value = 10'(v);
    @(negedge clk);
    if_a.div_load  = 1'b0;
  endtask

  // Scoreboard consumer: every strobe must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && (if_a.en_out || if_b.en_out || if_c.en_out)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe_cyc", cyc, -1);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("strobe_cyc", cyc, x.cyc);
        chk("en_a", if_a.en_out, 1);
        chk("en_b", if_b.en_out, 1);
        chk("en_c", if_c.en_out, 1);
        chk("idx_a", if_a.sample_idx, x.ia);
        chk("blk_a", if_a.blk_end, x.ba);
        chk("idx_b", if_b.sample_idx, x.ib);
        chk("blk_b", if_b.blk_end, x.bb);
        chk("idx_c", if_c.sample_idx, x.ic);
        chk("blk_c", if_c.blk_end, x.bc);
      end
    end
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int e, e2;
    if_a.run = 1'b0; if_a.div_load = 1'b0; if_a.div_value = '0;
`ifdef EN_GEN_SYNC_EN
    if_a.sync_in = 1'b0;
`endif
    // reset state
    @(negedge clk);
    chk("rst_en", if_a.en_out, 0);
    chk("rst_blk", if_a.blk_end, 0);
    chk("rst_idx", if_a.sample_idx, 0);
    chk("rst_busy", if_a.busy, 0);
    rst = 1'b0;

    // default divider: period 1000
    @(negedge clk);
    if_a.run = 1'b1; e = cyc + 1;
    for (int k = 0; k < 3; k++) push(e + 1000 * (k + 1), k);
    @(negedge clk);
    chk("t1_busy", if_a.busy, 1);
    chk("t1_en_start", if_a.en_out, 0);
    wait_cyc(e + 3005);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t1_busy_off", if_a.busy, 0);
    chk("t1_idx_clr", if_a.sample_idx, 0);
    chk("t1_q_empty", q.size(), 0);

    // div=3 loaded in IDLE
    load(3);
    if_a.run = 1'b1; e = cyc + 1;
    for (int k = 0; k < 10; k++) push(e + 4 * (k + 1), k);
    wait_cyc(e + 41);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t2_q_empty", q.size(), 0);

    // mid-period load, multiple loads, load in wrap cycle
    load(9);
    if_a.run = 1'b1; e = cyc + 1;
    push(e + 10, 0); push(e + 20, 1); push(e + 30, 2); push(e + 33, 3);
    push(e + 36, 4); push(e + 39, 5); push(e + 42, 6); push(e + 44, 7);
    push(e + 46, 8); push(e + 51, 9); push(e + 56, 10);
    wait_cyc(e + 25); load(2);
    wait_cyc(e + 39); load(7); load(1);
    wait_cyc(e + 45); load(4);
    wait_cyc(e + 57);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t3_q_empty", q.size(), 0);

    // div=0: strobe every clock, crosses the 205-sample block boundary
    load(0);
    if_a.run = 1'b1; e = cyc + 1;
    for (int k = 0; k < 210; k++) push(e + 1 + k, k);
    wait_cyc(e + 210);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t4_en_off", if_a.en_out, 0);
    chk("t4_busy_off", if_a.busy, 0);
    chk("t4_q_empty", q.size(), 0);

    // run dropped in the wrap cycle, rerun, async reset mid-period
    load(3);
    if_a.run = 1'b1; e = cyc + 1;
    push(e + 4, 0); push(e + 8, 1);
    wait_cyc(e + 11);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t5_drop_en", if_a.en_out, 0);
    chk("t5_drop_busy", if_a.busy, 0);
    chk("t5_drop_idx", if_a.sample_idx, 0);
    if_a.run = 1'b1; e2 = cyc + 1;
    push(e2 + 4, 0); push(e2 + 8, 1);
    wait_cyc(e2 + 10);
    rst = 1'b1; if_a.run = 1'b0;
    #1;
    chk("t5_arst_busy", if_a.busy, 0);
    chk("t5_arst_idx", if_a.sample_idx, 0);
    chk("t5_arst_blk", if_a.blk_end, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_q_empty", q.size(), 0);
    if_a.run = 1'b1; e = cyc + 1;
    push(e + 1000, 0);
    wait_cyc(e + 1001);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t5_default_q_empty", q.size(), 0);

`ifdef EN_GEN_SYNC_EN
    // sync pulse at count 2 realigns divider and block index
    load(4);
    if_a.run = 1'b1; e = cyc + 1;
    push(e + 5, 0); push(e + 10, 1); push(e + 18, 0); push(e + 23, 1);
    wait_cyc(e + 12);
    if_a.sync_in = 1'b1;
    @(negedge clk);
    if_a.sync_in = 1'b0;
    wait_cyc(e + 24);
    if_a.run = 1'b0;
    @(negedge clk);
    chk("t6_q_empty", q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    chk("final_q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
